ultrasonic_vehicle_detector: RTL and testbench
==============================================

Name: ultrasonic_vehicle_detector

Overview:
Sensor-side producer of the per-road vehicle-demand bit consumed by the traffic light controller (its x input). It periodically fires an ultrasonic trigger pulse and times the returned echo. It classifies each measurement as hit (vehicle within range) or miss, then applies hit/miss hysteresis. The result is a clean, synchronous car_present level. One instance per monitored road approach.

Parameters:
CNT_W, 22, width of all cycle counters and echo_width
TRIG_CYCLES, 500, trig high time in clk cycles (10 us @ 50 MHz)
RISE_TIMEOUT, 50000, max cycles from trig fall to echo rise before declaring timeout
ECHO_MAX, 1000000, max echo high cycles before declaring timeout
PERIOD, 3000000, cycles from one trig rise to the next (60 ms @ 50 MHz); must exceed TRIG_CYCLES+RISE_TIMEOUT+ECHO_MAX
THRESH, 150000, echo width strictly below this is a hit
HIT_COUNT, 3, consecutive hits required to assert car_present
MISS_COUNT, 3, consecutive misses required to deassert car_present

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
enable  input  1  measurement enable; low forces IDLE
echo  input  1  raw sensor echo, asynchronous to clk
trig  output  1  registered trigger pulse to sensor
car_present  output  1  filtered demand, drives controller x
echo_width  output  CNT_W  last completed echo width in cycles
width_valid  output  1  one-cycle strobe, echo_width updated
timeout  output  1  one-cycle strobe, measurement timed out

Behaviour:
- Reset is synchronous, active-high, on clock clk. On reset: state=IDLE; trig=0, car_present=0, echo_width=0, width_valid=0, timeout=0; all counters and the sync flops cleared.
- echo passes through a 2-flop synchroniser plus one delay flop. A rise or fall is an edge between the synchronised and delayed samples. This adds 2 cycles of latency; measured width is not affected.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: trig=0. If enable=1, go to TRIG on the next cycle and clear period_cnt.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE with wait_cnt=0.
- WAIT_RISE: only a rising edge counts; echo already high on entry is ignored. On a rise, go to MEASURE with width_cnt=1. If wait_cnt reaches RISE_TIMEOUT with no rise: pulse timeout, classify as miss, go to HOLDOFF.
- MEASURE: width_cnt increments each cycle the synchronised echo is high. On a fall: echo_width<=width_cnt, pulse width_valid, classify as hit if width_cnt<THRESH else miss, go to HOLDOFF. If width_cnt reaches ECHO_MAX: pulse timeout, classify as miss, leave echo_width unchanged, go to HOLDOFF.
- HOLDOFF: wait until period_cnt==PERIOD-1, then go to TRIG. period_cnt counts from trig rise, so trig rises every PERIOD cycles exactly.
- Hysteresis counters:
  - On a hit: miss_cnt=0, hit_cnt increments, saturating at HIT_COUNT.
  - On a miss: hit_cnt=0, miss_cnt increments, saturating at MISS_COUNT.
  - car_present sets on the cycle after hit_cnt reaches HIT_COUNT.
  - car_present clears on the cycle after miss_cnt reaches MISS_COUNT.
  - Otherwise car_present holds its value.
- width_valid and timeout are mutually exclusive; each is high for exactly one cycle per measurement.
- enable=0 in any state: next cycle state=IDLE, trig=0, hit_cnt/miss_cnt cleared, car_present cleared to 0. Any in-flight measurement is discarded with no strobe.
- rst mid-measurement behaves identically to a power-on reset.
- Echo activity in IDLE, TRIG or HOLDOFF is ignored.

Decomposition:
- Shared package (traffic_pkg): FSM state encoding constants, and the RED/YELLOW/GREEN light code constants already used by the controller.
- One sub-module: echo_sync (2-flop synchroniser, delay flop, rise/fall outputs).
- All timing parameters stay on the top module.

Test Plan:
Overrides: TRIG_CYCLES=4, RISE_TIMEOUT=20, ECHO_MAX=100, PERIOD=200, THRESH=30, HIT_COUNT=2, MISS_COUNT=2, CNT_W=8.
1. Reset, then enable=1 -> all outputs 0 during reset; trig high exactly 4 cycles, re-rising every 200 cycles.
2. Echo of 10 cycles, 5 cycles after trig fall, for two periods -> width_valid pulses with echo_width=10 each time; car_present rises 1 cycle after the second pulse.
3. From car_present=1, two echoes of 50 cycles -> echo_width=50; car_present stays 1 after the first, clears after the second.
4. echo held 0 -> timeout pulses 20 cycles after each trig fall, no width_valid; car_present stays 0.
5. echo stuck high from before trig -> no rise detected, timeout via RISE_TIMEOUT. Echo rising after trig and held 150 cycles -> timeout at width 100; echo_width unchanged.
6. Hit, hit (car_present=1), then drop enable mid-MEASURE -> next cycle IDLE, trig=0, car_present=0, no strobe. Re-enable -> needs 2 fresh hits to reassert.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light subsystem: light codes used by the controller and
// the measurement FSM states of the ultrasonic vehicle detector.
package traffic_pkg;

  localparam logic [1:0] LightRed    = 2'd0;
  localparam logic [1:0] LightYellow = 2'd1;
  localparam logic [1:0] LightGreen  = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StHoldoff
  } det_state_e;

endpackage

// File: rtl/echo_sync.sv
// Brings the asynchronous sensor echo into the clk domain and flags its edges.
module echo_sync (
  input  logic clk,
  input  logic rst,
  input  logic echo_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;

  always_comb begin
    sync1_d = echo_i;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~dly_q;
  assign fall_o  = ~sync2_q & dly_q;

endmodule

// File: rtl/ultrasonic_vehicle_detector.sv
// Periodically pings an ultrasonic sensor, times the echo, and filters hit/miss results
// into a clean car_present level for the traffic light controller.
module ultrasonic_vehicle_detector
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned TRIG_CYCLES  = 500,
  parameter int unsigned RISE_TIMEOUT = 50000,
  parameter int unsigned ECHO_MAX     = 1000000,
  parameter int unsigned PERIOD       = 3000000,
  parameter int unsigned THRESH       = 150000,
  parameter int unsigned HIT_COUNT    = 3,
  parameter int unsigned MISS_COUNT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             echo,
  output logic             trig,
  output logic             car_present,
  output logic [CNT_W-1:0] echo_width,
  output logic             width_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TrigLast   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RiseLast   = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EchoMax    = CNT_W'(ECHO_MAX);
  localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] Thresh     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] HitMax     = CNT_W'(HIT_COUNT);
  localparam logic [CNT_W-1:0] MissMax    = CNT_W'(MISS_COUNT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  logic echo_level, echo_rise, echo_fall;

  echo_sync u_echo_sync (
    .clk     (clk),
    .rst     (rst),
    .echo_i  (echo),
    .level_o (echo_level),
    .rise_o  (echo_rise),
    .fall_o  (echo_fall)
  );

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] echo_width_q, echo_width_d;
  logic             trig_q, trig_d;
  logic             car_present_q, car_present_d;
  logic             width_valid_q, width_valid_d;
  logic             timeout_q, timeout_d;
  logic             hit, miss;

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q + One;
    wait_cnt_d    = wait_cnt_q;
    width_cnt_d   = width_cnt_q;
    echo_width_d  = echo_width_q;
    trig_d        = 1'b0;
    width_valid_d = 1'b0;
    timeout_d     = 1'b0;
    hit           = 1'b0;
    miss          = 1'b0;

    unique case (state_q)
      StIdle: begin
        period_cnt_d = '0;
        if (enable) begin
          state_d = StTrig;
          trig_d  = 1'b1;
        end
      end
      StTrig: begin
        trig_d = 1'b1;
        if (period_cnt_q == TrigLast) begin
          trig_d     = 1'b0;
          state_d    = StWaitRise;
          wait_cnt_d = '0;
        end
      end
      StWaitRise: begin
        wait_cnt_d = wait_cnt_q + One;
        if (echo_rise) begin
          state_d     = StMeasure;
          width_cnt_d = One;
        end else if (wait_cnt_q == RiseLast) begin
          timeout_d = 1'b1;
          miss      = 1'b1;
          state_d   = StHoldoff;
        end
      end
      StMeasure: begin
        // A fall on the same cycle the cap is reached still yields a valid width.
        if (echo_fall) begin
          echo_width_d  = width_cnt_q;
          width_valid_d = 1'b1;
          hit           = (width_cnt_q < Thresh);
          miss          = ~(width_cnt_q < Thresh);
          state_d       = StHoldoff;
        end else if (width_cnt_q == EchoMax) begin
          timeout_d = 1'b1;
          miss      = 1'b1;
          state_d   = StHoldoff;
        end else if (echo_level) begin
          width_cnt_d = width_cnt_q + One;
        end
      end
      StHoldoff: begin
        if (period_cnt_q == PeriodLast) begin
          state_d      = StTrig;
          trig_d       = 1'b1;
          period_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit) begin
      miss_cnt_d = '0;
      if (hit_cnt_q != HitMax) hit_cnt_d = hit_cnt_q + One;
    end
    if (miss) begin
      hit_cnt_d = '0;
      if (miss_cnt_q != MissMax) miss_cnt_d = miss_cnt_q + One;
    end

    car_present_d = car_present_q;
    if (hit_cnt_q == HitMax) begin
      car_present_d = 1'b1;
    end else if (miss_cnt_q == MissMax) begin
      car_present_d = 1'b0;
    end

    // Disabling abandons any in-flight measurement silently and forgets the filter history.
    if (!enable) begin
      state_d       = StIdle;
      period_cnt_d  = '0;
      wait_cnt_d    = '0;
      width_cnt_d   = '0;
      echo_width_d  = echo_width_q;
      trig_d        = 1'b0;
      width_valid_d = 1'b0;
      timeout_d     = 1'b0;
      hit_cnt_d     = '0;
      miss_cnt_d    = '0;
      car_present_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      period_cnt_q  <= '0;
      wait_cnt_q    <= '0;
      width_cnt_q   <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      echo_width_q  <= '0;
      trig_q        <= 1'b0;
      car_present_q <= 1'b0;
      width_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      width_cnt_q   <= width_cnt_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      echo_width_q  <= echo_width_d;
      trig_q        <= trig_d;
      car_present_q <= car_present_d;
      width_valid_q <= width_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign trig        = trig_q;
  assign car_present = car_present_q;
  assign echo_width  = echo_width_q;
  assign width_valid = width_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_ultrasonic_vehicle_detector.sv
// Directed bench: one table row per measurement period, plus hand sequences for reset,
// enable start-up and dropping enable mid-measurement.
module tb_ultrasonic_vehicle_detector;

  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, enable, echo;
  logic             trig, car_present, width_valid, timeout;
  logic [CNT_W-1:0] echo_width;

  always #5 clk = ~clk;

  ultrasonic_vehicle_detector #(
    .CNT_W        (CNT_W),
    .TRIG_CYCLES  (4),
    .RISE_TIMEOUT (20),
    .ECHO_MAX     (100),
    .PERIOD       (200),
    .THRESH       (30),
    .HIT_COUNT    (2),
    .MISS_COUNT   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .echo        (echo),
    .trig        (trig),
    .car_present (car_present),
    .echo_width  (echo_width),
    .width_valid (width_valid),
    .timeout     (timeout)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int falls_used = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor, sampled on the falling edge.
  int   n_valid = 0, n_tmo = 0, n_both = 0, n_fall = 0;
  int   rise_cyc = -1, prev_rise_cyc = -1, fall_cyc = -1, strobe_cyc = -1;
  int   trig_len = 0, last_trig_len = 0;
  logic trig_prev = 1'b0, car_at_strobe = 1'b0;

  always @(negedge clk) begin
    trig_prev <= trig;
    if (trig) trig_len <= trig_prev ? trig_len + 1 : 1;
    if (trig && !trig_prev) begin
      prev_rise_cyc <= rise_cyc;
      rise_cyc      <= cyc;
    end
    if (!trig && trig_prev) begin
      fall_cyc      <= cyc;
      last_trig_len <= trig_len;
      n_fall        <= n_fall + 1;
    end
    if (width_valid || timeout) begin
      strobe_cyc    <= cyc;
      car_at_strobe <= car_present;
    end
    if (width_valid) n_valid <= n_valid + 1;
    if (timeout) n_tmo <= n_tmo + 1;
    if (width_valid && timeout) n_both <= n_both + 1;
  end

  typedef struct {
    int mode;        // 0: echo pulse after trig, 1: no echo, 2: echo high before trig
    int delay;
    int len;
    int chk_period;
    int exp_valid;   // 1: width_valid expected, 0: timeout expected
    int exp_width;
    int exp_lat;     // strobe cycle minus first trig-low cycle
    int exp_car_at;
    int exp_car_after;
  } row_t;

  row_t rows[12];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_fall(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      step();
      if (n_fall > falls_used) ok = 1'b1;
    end
    falls_used = n_fall;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s trig_fall: got none, expected one within 400 cycles", name);
    end
  endtask

  task automatic apply_row(input int idx);
    row_t  r;
    int    v0, t0, b0;
    bit    ok;
    string nm;
    r  = rows[idx];
    nm = $sformatf("row%0d", idx);
    v0 = n_valid;
    t0 = n_tmo;
    b0 = n_both;
    if (r.mode == 2) echo = 1'b1;
    wait_fall(nm, ok);
    if (!ok) return;
    check({nm, " trig_len"}, last_trig_len, 4);
    if (r.chk_period != 0) check({nm, " trig_period"}, rise_cyc - prev_rise_cyc, 200);
    if (r.mode == 0) begin
      repeat (r.delay) step();
      echo = 1'b1;
      repeat (r.len) step();
      echo = 1'b0;
    end
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (n_valid != v0 || n_tmo != t0) ok = 1'b1;
      else step();
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s strobe: got none, expected one within 300 cycles", nm);
      return;
    end
    check({nm, " latency"}, strobe_cyc - fall_cyc, r.exp_lat);
    check({nm, " car_at_strobe"}, int'(car_at_strobe), r.exp_car_at);
    step();
    check({nm, " car_after"}, int'(car_present), r.exp_car_after);
    if (r.mode == 2) echo = 1'b0;
    check({nm, " valid_pulses"}, n_valid - v0, r.exp_valid);
    check({nm, " timeout_pulses"}, n_tmo - t0, 1 - r.exp_valid);
    check({nm, " both_strobes"}, n_both - b0, 0);
    check({nm, " echo_width"}, int'(echo_width), r.exp_width);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int v0, t0;

    //           mode dly len per val wid lat at after
    rows[0]  = '{0, 5, 10,  0, 1, 10,  18, 0, 0};
    rows[1]  = '{0, 5, 10,  1, 1, 10,  18, 0, 1};
    rows[2]  = '{0, 5, 50,  1, 1, 50,  58, 1, 1};
    rows[3]  = '{0, 5, 50,  1, 1, 50,  58, 1, 0};
    rows[4]  = '{1, 0, 0,   1, 0, 50,  20, 0, 0};
    rows[5]  = '{1, 0, 0,   1, 0, 50,  20, 0, 0};
    rows[6]  = '{2, 0, 0,   1, 0, 50,  20, 0, 0};
    rows[7]  = '{0, 5, 150, 1, 0, 50, 108, 0, 0};
    rows[8]  = '{0, 5, 10,  1, 1, 10,  18, 0, 0};
    rows[9]  = '{0, 5, 10,  1, 1, 10,  18, 0, 1};
    rows[10] = '{0, 5, 10,  0, 1, 10,  18, 0, 0};
    rows[11] = '{0, 5, 10,  1, 1, 10,  18, 0, 1};

    rst    = 1'b1;
    enable = 1'b1;
    echo   = 1'b0;
    repeat (3) step();
    check("reset trig", int'(trig), 0);
    check("reset car_present", int'(car_present), 0);
    check("reset echo_width", int'(echo_width), 0);
    check("reset width_valid", int'(width_valid), 0);
    check("reset timeout", int'(timeout), 0);

    enable = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("disabled trig", int'(trig), 0);
    enable = 1'b1;
    step();
    check("trig_after_enable", int'(trig), 1);

    for (int i = 0; i < 10; i++) apply_row(i);

    // Drop enable while an echo is being measured; nothing may be reported.
    wait_fall("disable", ok);
    if (ok) begin
      repeat (5) step();
      echo = 1'b1;
      repeat (10) step();
      v0 = n_valid;
      t0 = n_tmo;
      enable = 1'b0;
      step();
      check("disable trig", int'(trig), 0);
      check("disable car_present", int'(car_present), 0);
      repeat (20) step();
      echo = 1'b0;
      repeat (20) step();
      check("disable valid_pulses", n_valid - v0, 0);
      check("disable timeout_pulses", n_tmo - t0, 0);
      check("disable echo_width", int'(echo_width), 10);
      check("disable trig_idle", int'(trig), 0);
      check("disable car_idle", int'(car_present), 0);
      enable = 1'b1;
      step();
      check("trig_after_reenable", int'(trig), 1);
    end

    for (int i = 10; i < 12; i++) apply_row(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
